shift_issue: RTL and testbench

SHIFT_ISSUE -- requirements
Module: shift_issue

---
 rtl/shift_issue.sv | 156 +++++++++++++++
 tb/tb_shift_issue.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// Command FIFO feeding an external registered shift_alu; issues one command at a time.
// Define SHIFT_ISSUE_BYPASS_EN to let an idle, empty issuer load the ALU directly.
`timescale 1ns/1ps

module shift_issue #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_data,
  input  logic [2:0]                   cmd_shift,
  input  logic [2:0]                   cmd_op,
  input  logic [3:0]                   cmd_tag,
  output logic                         alu_enable,
  output logic [31:0]                  alu_in,
  output logic [2:0]                   alu_shift,
  output logic [2:0]                   alu_op,
  input  logic [31:0]                  alu_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_data,
  output logic [3:0]                   res_tag,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  shift;
    logic [2:0]  op;
    logic [3:0]  tag;
  } cmd_t;

  state_t             r_state;
  state_t             w_state_next;
  cmd_t               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_count;
  logic [3:0]         r_tag;

  cmd_t               w_cmd_in;
  cmd_t               w_issue;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic               w_load;

  assign w_cmd_in   = '{data: cmd_data, shift: cmd_shift, op: cmd_op, tag: cmd_tag};
  assign w_full     = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign cmd_ready  = ~w_full;
  assign fifo_level = r_count;
  assign w_accept   = cmd_valid & cmd_ready;

`ifdef SHIFT_ISSUE_BYPASS_EN
  assign w_bypass = w_accept & w_empty & (r_state == IDLE);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed command never touches the FIFO storage or its pointers.
  assign w_push  = w_accept & ~w_bypass;
  assign w_pop   = (r_state == IDLE) & ~w_empty;
  assign w_load  = w_pop | w_bypass;
  assign w_issue = w_pop ? r_mem[r_rd_ptr] : w_cmd_in;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_cmd_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_next = EXEC;
      EXEC:    w_state_next = WAIT;
      WAIT:    w_state_next = DONE;
      DONE:    if (res_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // alu_enable follows the load strobe, so it is high only in the EXEC cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_enable <= 1'b0;
      alu_in     <= '0;
      alu_shift  <= '0;
      alu_op     <= '0;
      r_tag      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_tag    <= '0;
    end else begin
      alu_enable <= w_load;
      if (w_load) begin
        alu_in    <= w_issue.data;
        alu_shift <= w_issue.shift;
        alu_op    <= w_issue.op;
        r_tag     <= w_issue.tag;
      end
      if (r_state == WAIT) begin
        res_data  <= alu_out;
        res_tag   <= r_tag;
        res_valid <= 1'b1;
      end else if ((r_state == DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Randomized self-checking bench for shift_issue with a queue-based reference
// model and a behavioural stand-in for the registered shift_alu.
`timescale 1ns/1ps

`ifndef SHLEFTLOG
`define SHLEFTLOG 3'b000
`endif
`ifndef SHLEFTART
`define SHLEFTART 3'b001
`endif
`ifndef SHRGHTLOG
`define SHRGHTLOG 3'b010
`endif
`ifndef SHRGHTART
`define SHRGHTART 3'b011
`endif

module tb_shift_issue;

  localparam int unsigned DEPTH = 4;
`ifdef SHIFT_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  // Edges from the accepting edge to the first cycle showing res_valid.
  localparam int LAT = BYP ? 2 : 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic [2:0]  cmd_shift = '0;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_tag = '0;
  logic        alu_enable;
  logic [31:0] alu_in;
  logic [2:0]  alu_shift;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic [2:0]  fifo_level;

  shift_issue #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_shift  (cmd_shift),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_enable (alu_enable),
    .alu_in     (alu_in),
    .alu_shift  (alu_shift),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] shf(input logic [31:0] d, input logic [2:0] s, input logic [2:0] op);
    logic [31:0] r;
    case (op)
      `SHLEFTLOG: r = d << s;
      `SHLEFTART: r = d << s;
      `SHRGHTLOG: r = d >> s;
      `SHRGHTART: r = $unsigned($signed(d) >>> s);
      default:    r = d;
    endcase
    return r;
  endfunction

  // Registered shift_alu stand-in, reset from ~reset_n.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) alu_out <= '0;
    else if (alu_enable) alu_out <= shf(alu_in, alu_shift, alu_op);
  end

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  s;
    logic [2:0]  op;
    logic [3:0]  tag;
  } cmd_t;

  cmd_t        q[$];
  bit          busy = 1'b0;
  int          age = 0;
  cmd_t        cur = '0;
  cmd_t        m_alu = '0;
  logic [31:0] m_res_data = '0;
  logic [3:0]  m_res_tag = '0;
  cmd_t        m_inc;
  cmd_t        m_iss;
  bit          m_acc;
  bit          m_hs;
  bit          m_issue;

  // Reference model: age counts cycles since issue (1 = ALU enabled, 3+ = result held).
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      busy = 1'b0;
      age = 0;
      cur = '0;
      m_alu = '0;
      m_res_data = '0;
      m_res_tag = '0;
    end else begin
      m_inc   = {cmd_data, cmd_shift, cmd_op, cmd_tag};
      m_acc   = cmd_valid && (q.size() < DEPTH);
      m_hs    = busy && (age >= 3) && res_ready;
      m_issue = 1'b0;
      if (!busy && q.size() > 0) begin
        m_iss = q.pop_front();
        m_issue = 1'b1;
      end else if (BYP && !busy && m_acc) begin
        m_iss = m_inc;
        m_issue = 1'b1;
        m_acc = 1'b0;
      end
      if (m_acc) q.push_back(m_inc);
      if (m_hs) busy = 1'b0;
      if (m_issue) begin
        busy = 1'b1;
        age = 1;
        cur = m_iss;
        m_alu = m_iss;
      end else if (busy && age == 1) begin
        age = 2;
      end else if (busy && age == 2) begin
        age = 3;
        m_res_data = shf(cur.d, cur.s, cur.op);
        m_res_tag = cur.tag;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    check("cmd_ready",  32'(cmd_ready),  32'(q.size() < DEPTH));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("alu_enable", 32'(alu_enable), 32'(busy && age == 1));
    check("alu_in",     alu_in,          m_alu.d);
    check("alu_shift",  32'(alu_shift),  32'(m_alu.s));
    check("alu_op",     32'(alu_op),     32'(m_alu.op));
    check("res_valid",  32'(res_valid),  32'(busy && age >= 3));
    check("res_data",   res_data,        m_res_data);
    check("res_tag",    32'(res_tag),    32'(m_res_tag));
  end

  bit         collect = 1'b0;
  logic [3:0] got[$];

  always @(negedge clock) begin
    #4;
    if (collect && reset_n && res_valid && res_ready) got.push_back(res_tag);
  end

  // All stimulus tasks are entered and left just after a falling edge.
  task automatic push_cmd(input logic [31:0] d, input logic [2:0] s, input logic [2:0] op,
                          input logic [3:0] t, output int acc_edge);
    cmd_data = d;
    cmd_shift = s;
    cmd_op = op;
    cmd_tag = t;
    cmd_valid = 1'b1;
    acc_edge = -1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin
        acc_edge = cyc + 1;
        @(posedge clock);
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    if (acc_edge < 0) check("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !busy) return;
      @(negedge clock);
    end
    check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_one(input logic [31:0] d, input logic [2:0] s, input logic [2:0] op,
                         input logic [3:0] t, input logic [31:0] expd);
    int acc;
    res_ready = 1'b1;
    push_cmd(d, s, op, t, acc);
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      @(negedge clock);
    end
    check("latency",  32'(cyc - acc), 32'(LAT));
    check("dir_data", res_data, expd);
    check("dir_tag",  32'(res_tag), 32'(t));
    drain();
  endtask

  initial begin
    int acc;
    bit found;

    cmd_valid = 1'b1;
    cmd_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clock);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_en",    32'(alu_enable), 32'd0);
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    run_one(32'h8000_0000, 3'd3, `SHRGHTART, 4'd5, 32'hF000_0000);
    run_one(32'h8000_0000, 3'd3, `SHRGHTLOG, 4'd6, 32'h1000_0000);
    run_one(32'h0000_0001, 3'd3, `SHLEFTLOG, 4'd7, 32'h0000_0008);

    // Back-pressure: one in flight plus a full FIFO, then a stalled sixth command.
    res_ready = 1'b0;
    collect = 1'b1;
    got.delete();
    for (int t = 1; t <= 5; t++) push_cmd($urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 4'(t), acc);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    cmd_data = 32'h1234_5678;
    cmd_tag = 4'd6;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clock);
    res_ready = 1'b1;
    push_cmd(32'h1234_5678, 3'd1, `SHLEFTART, 4'd6, acc);
    drain();
    collect = 1'b0;
    check("n_results", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++) check("order", 32'(got[i]), 32'(i + 1));

    // Reset while the ALU is enabled discards the command.
    push_cmd(32'hCAFE_0000, 3'd4, `SHRGHTLOG, 4'd8, acc);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (alu_enable) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("saw_alu_enable", 32'(found), 32'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("no_res_after_rst", 32'(res_valid), 32'd0);
    end
    run_one(32'h0000_00F0, 3'd2, `SHRGHTLOG, 4'd9, 32'h0000_003C);

    // Push exactly on pop edges at level 2, enough times to wrap the pointers.
    res_ready = 1'b0;
    for (int t = 0; t < 3; t++) push_cmd($urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 4'(t), acc);
    check("lvl_two", 32'(fifo_level), 32'd2);
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (!busy && q.size() > 0) begin
          found = 1'b1;
          break;
        end
        @(negedge clock);
      end
      check("pop_slot", 32'(found), 32'd1);
      push_cmd($urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 4'((k + 3) % 16), acc);
      check("lvl_keep2", 32'(fifo_level), 32'd2);
    end
    drain();

    for (int i = 0; i < 600; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data = $urandom;
      cmd_shift = 3'($urandom_range(0, 7));
      cmd_op = 3'($urandom_range(0, 7));
      cmd_tag = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 9) < 7);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
